// File: rtl/mod_reduce_25519_pkg.sv
// Shared definitions for the GF(2^255-19) reduction block.
//   P_25519        : the field prime 2^255 - 19
//   FOLD_K / TOP_K : fold multipliers (2^256 == 38, 2^255 == 19 mod p)
//   LIMB_W/N_LIMB  : limb width and limb count per 256-bit half
//   CARRY_W        : width of the inter-limb fold carry
//   state_t        : sequencer states
package mod_reduce_25519_pkg;

  localparam logic [255:0] P_25519 = {1'b0, {255{1'b1}}} - 256'd18;

  localparam int FOLD_K  = 38;
  localparam int TOP_K   = 19;
  localparam int LIMB_W  = 16;
  localparam int N_LIMB  = 16;
  localparam int CARRY_W = 7;

  typedef enum logic [1:0] {
    IDLE,
    FOLD1,
    FOLD2,
    SUB
  } state_t;

endpackage

// File: rtl/mod_reduce_25519_if.sv
// Request/result bundle of mod_reduce_25519.
//   start : request, sampled only while the reducer is idle
//   in    : 512-bit unsigned product to reduce
//   out   : canonical residue in mod p (bit 255 always 0)
//   done  : one-cycle pulse, out valid from this cycle
//   busy  : high whenever the reducer is not idle
// master drives the request side, slave is the reducer.
interface mod_reduce_25519_if;

  logic         start;
  logic [511:0] in;
  logic [255:0] out;
  logic         done;
  logic         busy;

  modport master (
    output start,
    output in,
    input  out,
    input  done,
    input  busy
  );

  modport slave (
    input  start,
    input  in,
    output out,
    output done,
    output busy
  );

endinterface

// File: rtl/mod_reduce_25519_fold_limb.sv
// Combinational limb fold for the first reduction pass:
//   {carry_out, sum} = lo + FOLD_K * hi + carry_in
// Ports:
//   lo, hi     : matching limbs of the low and high 256-bit halves
//   carry_in   : carry from the previous limb
//   sum        : folded limb
//   carry_out  : carry into the next limb (at most FOLD_K for 16-bit limbs)
module fold_limb
  import mod_reduce_25519_pkg::*;
#(
  parameter int LIMB_W = mod_reduce_25519_pkg::LIMB_W
) (
  input  logic [LIMB_W-1:0]  lo,
  input  logic [LIMB_W-1:0]  hi,
  input  logic [CARRY_W-1:0] carry_in,
  output logic [LIMB_W-1:0]  sum,
  output logic [CARRY_W-1:0] carry_out
);

  localparam int SUM_W = LIMB_W + CARRY_W;

  logic [SUM_W-1:0] s;

  always_comb begin
    s         = SUM_W'(lo) + SUM_W'(hi) * SUM_W'(FOLD_K) + SUM_W'(carry_in);
    sum       = s[LIMB_W-1:0];
    carry_out = s[SUM_W-1:LIMB_W];
  end

endmodule

// File: rtl/mod_reduce_25519.sv
// Sequential reduction of a 512-bit product modulo p = 2^255 - 19.
//   FOLD1 : one limb per cycle, acc = lo + 38*hi with carry c out of the top
//   FOLD2 : t = acc[254:0] + 19*(acc[255] + 2*c)   (t < 2p)
//   SUB   : out = (t >= p) ? t - p : t, done pulses
// Fixed latency: done rises 18 edges after the accepting edge.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : slave side of mod_reduce_25519_if (start/in/out/done/busy)
module mod_reduce_25519
  import mod_reduce_25519_pkg::*;
#(
  parameter int LIMB_W = mod_reduce_25519_pkg::LIMB_W,
  parameter int N_LIMB = mod_reduce_25519_pkg::N_LIMB
) (
  input  logic              clk,
  input  logic              reset,
  mod_reduce_25519_if.slave bus
);

  localparam int CNT_W = $clog2(N_LIMB);

  state_t state, state_nxt;

  logic [511:0]       in_r;
  logic [255:0]       acc;
  logic [CNT_W-1:0]   cnt;
  logic [CARRY_W-1:0] carry;
  logic [255:0]       t_r;
  logic [255:0]       out_r;
  logic               done_r;
  logic               busy_c;

  logic               last_limb;
  int                 limb_base;
  logic [LIMB_W-1:0]  lo_limb;
  logic [LIMB_W-1:0]  hi_limb;
  logic [LIMB_W-1:0]  fold_sum;
  logic [CARRY_W-1:0] fold_carry;

  logic [7:0]         top_cnt;
  logic [12:0]        top_add;
  logic [255:0]       t_nxt;
  logic [255:0]       sub_nxt;

  assign last_limb = (cnt == CNT_W'(N_LIMB - 1));

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.start) state_nxt = FOLD1;
      FOLD1:   if (last_limb) state_nxt = FOLD2;
      FOLD2:   state_nxt = SUB;
      SUB:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy_c = (state != IDLE);
  end

  // Limb selection for the current fold step
  always_comb begin
    limb_base = int'(cnt) * LIMB_W;
    lo_limb   = in_r[limb_base +: LIMB_W];
    hi_limb   = in_r[256 + limb_base +: LIMB_W];
  end

  fold_limb #(
    .LIMB_W (LIMB_W)
  ) u_fold (
    .lo        (lo_limb),
    .hi        (hi_limb),
    .carry_in  (carry),
    .sum       (fold_sum),
    .carry_out (fold_carry)
  );

  // Second fold: bit 255 and the FOLD1 carry (worth 2^256 = 2*2^255)
  // both re-enter at weight 19.
  always_comb begin
    top_cnt = {carry, 1'b0} + 8'(acc[255]);
    top_add = 13'(top_cnt) * 13'(TOP_K);
    t_nxt   = {1'b0, acc[254:0]} + 256'(top_add);
    sub_nxt = (t_r >= P_25519) ? (t_r - P_25519) : t_r;
  end

  // Datapath
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_r   <= '0;
      acc    <= '0;
      cnt    <= '0;
      carry  <= '0;
      t_r    <= '0;
      out_r  <= '0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            in_r  <= bus.in;
            cnt   <= '0;
            carry <= '0;
          end
        end
        FOLD1: begin
          acc[limb_base +: LIMB_W] <= fold_sum;
          carry                    <= fold_carry;
          cnt                      <= last_limb ? '0 : cnt + 1'b1;
        end
        FOLD2: begin
          t_r <= t_nxt;
        end
        SUB: begin
          out_r  <= sub_nxt;
          done_r <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.out  = out_r;
  assign bus.done = done_r;
  assign bus.busy = busy_c;

endmodule

// File: doc/mod_reduce_25519.md
MOD_REDUCE_25519 -- requirements
Module: mod_reduce_25519

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 The ports SHALL be as follows, clock and reset first:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- in  input  512  product from the 256x256 multiplier stage, unsigned
- out  output  256  in mod p, with p = 2^255-19; bit 255 always 0
- done  output  1  one-cycle pulse; out valid from this cycle
- busy  output  1  high in every state except IDLE
REQ-003 The block SHALL have these parameters:
- LIMB_W, default 16, fold limb width in bits
- N_LIMB, default 16, number of limbs per 256-bit half

Function
REQ-004 The block SHALL compute out = in mod p for every 512-bit in, returning the canonical residue in [0, p-1].
REQ-005 The block SHALL have four states, IDLE, FOLD1, FOLD2 and SUB, with these transitions:
- IDLE->FOLD1 when start=1
- FOLD1->FOLD2 after limb N_LIMB-1
- FOLD2->SUB unconditionally
- SUB->IDLE unconditionally
REQ-006 On accept the block SHALL:
- latch in into an internal register
- clear the 4-bit limb counter and the 7-bit carry
REQ-007 Each FOLD1 cycle i (i = 0..15) SHALL compute:
- s = lo[16i+15:16i] + 38*hi[16i+15:16i] + carry
- acc limb i <= s[15:0]
- carry <= s >> 16
- the counter increments, and wraps at 15 to leave FOLD1
REQ-008 FOLD1 SHALL use the congruence 2^256 == 38 (mod p); the final carry c SHALL satisfy c <= 38, which fits the 7-bit carry.
REQ-009 FOLD2 SHALL compute t = acc[254:0] + 19*(acc[255] + 2*c), using 2^255 == 19; t < 2p is guaranteed and is held in a 256-bit register.
REQ-010 SUB SHALL perform one subtraction:
- if t >= p, out <= t - p
- otherwise out <= t
- done <= 1 in the same edge
REQ-011 Latency SHALL be fixed: done rises 18 rising edges after the edge at which start was sampled, independent of data.
REQ-012 done SHALL be high for exactly one cycle.
REQ-013 out SHALL hold its value until the next SUB edge.
REQ-014 Start handling SHALL be:
- start while busy=1 is ignored and not queued
- start in the cycle done=1 is accepted, because state is IDLE; back-to-back throughput is 1 result per 19 cycles
REQ-015 in is sampled only at the accept edge; later changes on in SHALL NOT affect the running reduction.
REQ-016 All arithmetic SHALL be unsigned, and no intermediate value SHALL be truncated below the widths stated in REQ-007 to REQ-009.

Reset
REQ-017 When reset=0 the block SHALL, asynchronously:
- force state to IDLE
- clear out, done, busy, the counter, the carry, acc, t and the input register
REQ-018 A reset asserted mid-operation SHALL abort the reduction with no done pulse; the first start after reset release is handled normally.
REQ-019 Reset release SHALL be synchronous to clk; no start is accepted on the release edge itself.

Structure
REQ-020 A shared package SHALL hold:
- P_25519 (256-bit constant)
- FOLD_K = 38 and TOP_K = 19
- LIMB_W and N_LIMB
- the state enum
REQ-021 One sub-module, fold_limb, SHALL be combinational and compute the REQ-007 limb sum (16-bit lo, 16-bit hi, 7-bit carry in -> 16-bit sum, 7-bit carry out); all sequencing SHALL stay in the top module.

Verification
REQ-022 in=0 -> out=0, done 18 edges after accept, busy high during those 18 cycles.
REQ-023 in=2^255-19 (p) -> out=0; in=2^255-20 (p-1) -> out=p-1; in=2^255 -> out=19.
REQ-024 in=2^256 -> out=38; in=2^512-1 -> out=1443 (0x5A3).
REQ-025 Start pulsed again 5 cycles after accept with a different in -> ignored, first result only; then start in the done cycle -> second result exactly 19 cycles later.
REQ-026 reset=0 at FOLD1 limb 7 -> out=0, done=0, busy=0 immediately; after release, in=2^256 -> out=38 with full latency.
REQ-027 1000 random 512-bit inputs -> out matches a reference model's mod p; bit 255 is never set.
